// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bus: stall requests and exception inputs from the
// stages, stall/flush/redirect and statistics back to them.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: stall merging, exception flush
// sequencing (deferred while MEM is bus-stalled), stall statistics, watchdog.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [31:0] CODE_INT   = 32'h0000_0001;
  localparam logic [31:0] CODE_ERET  = 32'h0000_000e;
  localparam logic [15:0] RUN_LIMIT  = 16'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_PEND} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pend_code;
  logic [31:0] r_pend_epc;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_run_cnt;
  logic        r_timeout;

  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_latch;
  logic [15:0] w_run_next;

  function automatic logic [31:0] redirect(input logic [31:0] code,
                                           input logic [31:0] epc);
    if (code == CODE_INT)       return INT_VECTOR;
    else if (code == CODE_ERET) return epc;
    else                        return EXC_VECTOR;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_stall      = STALL_NONE;
    w_flush      = 1'b0;
    w_new_pc     = 32'h0;
    w_latch      = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.excepttype_i != 32'h0 && !bus.stallreq_from_mem) begin
            w_flush  = 1'b1;
            w_new_pc = redirect(bus.excepttype_i, bus.cp0_epc_i);
          end else if (bus.excepttype_i != 32'h0) begin
            // MEM holds the bus: park the exception (and EPC) until release.
            w_stall      = STALL_MEM;
            w_latch      = 1'b1;
            w_state_next = ST_PEND;
          end else if (bus.stallreq_from_mem) begin
            w_stall = STALL_MEM;
          end else if (bus.stallreq_from_ex) begin
            w_stall = STALL_EX;
          end else if (bus.stallreq_from_id) begin
            w_stall = STALL_ID;
          end
        end
        ST_PEND: begin
          if (bus.stallreq_from_mem) begin
            w_stall = STALL_MEM;
          end else begin
            w_flush      = 1'b1;
            w_new_pc     = redirect(r_pend_code, r_pend_epc);
            w_state_next = ST_RUN;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_run_next = 16'h0;
    if (w_stall[0])
      w_run_next = (r_run_cnt >= RUN_LIMIT) ? RUN_LIMIT : r_run_cnt + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_pend_code    <= 32'h0;
      r_pend_epc     <= 32'h0;
      r_stall_cycles <= 32'h0;
      r_run_cnt      <= 16'h0;
      r_timeout      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_next;
      if (w_latch) begin
        r_pend_code <= bus.excepttype_i;
        r_pend_epc  <= bus.cp0_epc_i;
      end
      if (w_stall[0] && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_run_next == RUN_LIMIT)
        r_timeout <= 1'b1;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.new_pc        = w_new_pc;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared every cycle against a behavioural model of the controller rules.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit          m_pending;
  logic [31:0] m_pcode;
  logic [31:0] m_pepc;
  longint      m_cycles;
  int          m_consec;
  bit          m_tmo;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vec(input logic [31:0] code,
                                      input logic [31:0] epc);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return epc;
    return 32'h40;
  endfunction

  // Number of stopped stages from the front, turned into a mask.
  function automatic logic [5:0] prio_mask(input bit id, input bit ex,
                                           input bit mem);
    int n;
    n = mem ? 5 : ex ? 4 : id ? 3 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_comb();
    e_stall = 6'h0;
    e_flush = 1'b0;
    e_pc    = 32'h0;
    if (rst) return;
    if (m_pending) begin
      if (bus.stallreq_from_mem) e_stall = 6'h1f;
      else begin e_flush = 1'b1; e_pc = vec(m_pcode, m_pepc); end
    end else if (bus.excepttype_i != 0) begin
      if (bus.stallreq_from_mem) e_stall = 6'h1f;
      else begin e_flush = 1'b1; e_pc = vec(bus.excepttype_i, bus.cp0_epc_i); end
    end else begin
      e_stall = prio_mask(bus.stallreq_from_id, bus.stallreq_from_ex,
                          bus.stallreq_from_mem);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pending = 0; m_pcode = 0; m_pepc = 0;
      m_cycles = 0; m_consec = 0; m_tmo = 0;
      return;
    end
    if (e_stall[0]) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      m_consec++;
    end else begin
      m_consec = 0;
    end
    if (m_consec >= int'(TMO)) m_tmo = 1;
    if (m_pending) begin
      if (!bus.stallreq_from_mem) m_pending = 0;
    end else if (bus.excepttype_i != 0 && bus.stallreq_from_mem) begin
      m_pending = 1;
      m_pcode   = bus.excepttype_i;
      m_pepc    = bus.cp0_epc_i;
    end
  endtask

  // Inputs are already set; check outputs mid-cycle, then clock the model.
  task automatic cycle(input string ph);
    #2;
    model_comb();
    check({ph, ".stall"},  32'(bus.stall),  32'(e_stall));
    check({ph, ".flush"},  32'(bus.flush),  32'(e_flush));
    check({ph, ".new_pc"}, bus.new_pc,      e_pc);
    check({ph, ".cycles"}, bus.stall_cycles, m_cycles[31:0]);
    check({ph, ".tmo"},    32'(bus.stall_timeout), 32'(m_tmo));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    rst                   = r;
    bus.stallreq_from_id  = id;
    bus.stallreq_from_ex  = ex;
    bus.stallreq_from_mem = mem;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
  endtask

  logic [31:0] codes [8];

  initial begin
    codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h7fff_0000};
    m_pending = 0; m_pcode = 0; m_pepc = 0;
    m_cycles = 0; m_consec = 0; m_tmo = 0;

    // Reset with requests active: outputs must still be zero.
    drive(1, 1, 1, 1, 32'h8, 32'h0);
    @(posedge clk); #1;
    cycle("reset");
    drive(0, 0, 0, 0, 0, 0);
    cycle("idle");

    // Stall priority.
    drive(0, 1, 1, 0, 0, 0);
    repeat (3) cycle("prio_idex");
    drive(0, 1, 1, 1, 0, 0);
    repeat (2) cycle("prio_mem");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cycle("prio_none");
    check("prio_total", bus.stall_cycles, 32'd5);

    // Flush in RUN beats an ID stall.
    drive(0, 1, 0, 0, 32'h8, 0);
    cycle("flush_exc");
    drive(0, 0, 0, 0, 0, 0);
    cycle("flush_after");

    // Interrupt and eret.
    drive(0, 0, 0, 0, 32'h1, 32'h0);
    cycle("int");
    drive(0, 0, 1, 0, 32'he, 32'h0000_1234);
    cycle("eret");

    // Pending flush uses the EPC captured at entry.
    drive(0, 0, 0, 1, 32'he, 32'hA0);
    cycle("pend1");
    drive(0, 1, 1, 1, 32'he, 32'hB0);
    cycle("pend2");
    cycle("pend3");
    drive(0, 1, 0, 0, 32'h0, 32'hB0);
    cycle("pend_fire");
    check("pend_pc", bus.new_pc, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    cycle("pend_back");

    // Watchdog: flag sets after TMO stalled cycles and sticks.
    drive(0, 0, 1, 0, 0, 0);
    repeat (TMO + 2) cycle("wdog_hold");
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle("wdog_release");
    check("wdog_sticky", 32'(bus.stall_timeout), 32'd1);

    // Reset while pending discards the exception.
    drive(0, 0, 0, 1, 32'h8, 32'h0);
    cycle("rpend_enter");
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    cycle("rpend_hold");
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    cycle("rpend_rst");
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("rpend_after");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] exc;
      exc = ($urandom_range(0, 9) < 7) ? 32'h0 : codes[$urandom_range(0, 7)];
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            exc, $urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
